// File: rtl/ro_pkg.sv
// Shared state type, width helper and default parameters for the readout slot sequencer.
package ro_pkg;
    localparam int RO_N_CH_DEF     = 8;
    localparam int RO_SLOT_LEN_DEF = 2;
    localparam int RO_GAP_LEN_DEF  = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GAP   = 2'd1,
        ST_DRIVE = 2'd2
    } ro_state_e;

    // Bits needed to encode values 0..n-1; never narrower than 1.
    function automatic int ro_clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction
endpackage

// File: rtl/ro_req_latch.sv
// Per-channel pending flag: set by a request strobe, cleared by the slot acknowledge; set wins.
module ro_req_latch (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic clr,
    output logic pend
);
    logic pend_q, pend_d;

    always_comb begin
        pend_d = set | (pend_q & ~clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend_q <= 1'b0;
        else     pend_q <= pend_d;
    end

    assign pend = pend_q;
endmodule

// File: rtl/ro_slot_sequencer.sv
// Break-before-make TDM sequencer granting a shared tristate bus to N_CH readout channels.
// Define RO_SEQ_SKIP_IDLE_EN to skip channels without a pending request.
module ro_slot_sequencer
    import ro_pkg::*;
#(
    parameter int N_CH     = RO_N_CH_DEF,
    parameter int SLOT_LEN = RO_SLOT_LEN_DEF,
    parameter int GAP_LEN  = RO_GAP_LEN_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [N_CH-1:0]           req,
    output logic [N_CH-1:0]           ctrl,
    output logic [N_CH-1:0]           ack,
    output logic [ro_clog2(N_CH)-1:0] ch_id,
    output logic                      slot_vld,
    output logic                      frame_start,
    output logic                      busy
);
    localparam int ID_W  = ro_clog2(N_CH);
    localparam int CNT_W = ro_clog2((SLOT_LEN > GAP_LEN) ? SLOT_LEN : GAP_LEN);
    localparam logic [ID_W-1:0]  LAST_CH = ID_W'(N_CH - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_LEN - 1);
    localparam logic [CNT_W-1:0] SLOT_LD = CNT_W'(SLOT_LEN - 1);

    ro_state_e        state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_CH-1:0]  ctrl_q, ctrl_d, ack_q, ack_d;
    logic [ID_W-1:0]  ch_id_q, ch_id_d;
    logic             slot_vld_q, slot_vld_d, frame_start_q, frame_start_d, busy_q, busy_d;
    logic             frame_done, frame_last;
    logic [N_CH-1:0]  pending;

    for (genvar k = 0; k < N_CH; k++) begin : g_pend
        ro_req_latch u_latch (
            .clk  (clk),
            .rst  (rst),
            .set  (req[k]),
            .clr  (ack_q[k]),
            .pend (pending[k])
        );
    end

`ifdef RO_SEQ_SKIP_IDLE_EN
    logic            hit_at, hit_after;
    logic [ID_W-1:0] hit_idx;

    // Lowest pending channel at/after ptr; also whether anything waits beyond ptr.
    always_comb begin
        hit_at    = 1'b0;
        hit_after = 1'b0;
        hit_idx   = ptr_q;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (pending[k] && (k >= int'(ptr_q))) begin
                hit_at  = 1'b1;
                hit_idx = ID_W'(k);
            end
            if (pending[k] && (k > int'(ptr_q))) hit_after = 1'b1;
        end
    end

    assign frame_last = (ptr_q == LAST_CH) || !hit_after;
`else
    assign frame_last = (ptr_q == LAST_CH);
`endif

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        slot_vld_d    = 1'b0;
        frame_start_d = 1'b0;
        frame_done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d       = ST_GAP;
                    ptr_d         = '0;
                    cnt_d         = GAP_LD;
                    frame_start_d = 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
`ifdef RO_SEQ_SKIP_IDLE_EN
                    if (hit_at) begin
                        state_d    = ST_DRIVE;
                        ptr_d      = hit_idx;
                        cnt_d      = SLOT_LD;
                        slot_vld_d = 1'b1;
                    end else begin
                        frame_done = 1'b1;
                    end
`else
                    state_d    = ST_DRIVE;
                    cnt_d      = SLOT_LD;
                    slot_vld_d = pending[ptr_q];
`endif
                end
            end
            ST_DRIVE: begin
                if (cnt_q != '0) begin
                    cnt_d      = cnt_q - CNT_W'(1);
                    slot_vld_d = slot_vld_q;
                end else if (frame_last) begin
                    frame_done = 1'b1;
                end else begin
                    state_d = ST_GAP;
                    ptr_d   = ptr_q + ID_W'(1);
                    cnt_d   = GAP_LD;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // en is only honoured here, so a running frame always completes.
        if (frame_done) begin
            ptr_d = '0;
            cnt_d = GAP_LD;
            if (en) begin
                state_d       = ST_GAP;
                frame_start_d = 1'b1;
            end else begin
                state_d = ST_IDLE;
            end
        end

        busy_d  = (state_d != ST_IDLE);
        ctrl_d  = '0;
        ack_d   = '0;
        ch_id_d = '0;
        if (state_d == ST_DRIVE) begin
            ctrl_d[ptr_d] = 1'b1;
            ack_d[ptr_d]  = (cnt_d == '0);
            ch_id_d       = ptr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            cnt_q         <= '0;
            ctrl_q        <= '0;
            ack_q         <= '0;
            ch_id_q       <= '0;
            slot_vld_q    <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            ctrl_q        <= ctrl_d;
            ack_q         <= ack_d;
            ch_id_q       <= ch_id_d;
            slot_vld_q    <= slot_vld_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
        end
    end

    assign ctrl        = ctrl_q;
    assign ack         = ack_q;
    assign ch_id       = ch_id_q;
    assign slot_vld    = slot_vld_q;
    assign frame_start = frame_start_q;
    assign busy        = busy_q;
endmodule
